// File: rtl/serial_uart_bridge.sv
// rtl/serial_uart_bridge.sv - byte-strobe to UART bridge with TX/RX FIFOs; optional even parity under `PARITY_EN
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  input  logic       rx_rden_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       tx_ready_out,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       overrun_out,
`ifdef PARITY_EN
  output logic       parity_err_out,
`endif
  output logic       frame_err_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]         tx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [FIFO_AW:0]   tx_count;
  logic               tx_push, tx_pop;

  assign tx_ready_out = (tx_count != FIFO_FULL);
  assign tx_push      = tx_wren_in && tx_ready_out;

  // TX FIFO storage, pointers and occupancy; push and pop may coincide
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= tx_data_in;
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- TX serializer ----------------
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_d;
  logic            tx_cnt_last;
`ifdef PARITY_EN
  logic            tx_par_q, tx_par_d;
`endif

  assign tx_cnt_last = (tx_cnt_q == CNT_LAST);

  // TX state register; the line itself is registered so it changes on the load edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx    <= 1'b1;
`ifdef PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      uart_tx    <= tx_line_d;
`ifdef PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // TX next state: load from FIFO in IDLE or straight after STOP so frames run back to back
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = uart_tx;
    tx_pop     = 1'b0;
`ifdef PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd_ptr];
`ifdef PARITY_EN
          tx_par_d   = ^tx_mem[tx_rd_ptr];
`endif
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
`ifdef PARITY_EN
            tx_line_d  = tx_par_q;
            tx_state_d = ST_PARITY;
`else
            tx_line_d  = 1'b1;
            tx_state_d = ST_STOP;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_last) begin
          tx_cnt_d   = '0;
          tx_line_d  = 1'b1;
          tx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_last) begin
          tx_cnt_d = '0;
          if (tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rd_ptr];
`ifdef PARITY_EN
            tx_par_d   = ^tx_mem[tx_rd_ptr];
`endif
            tx_line_d  = 1'b0;
            tx_state_d = ST_START;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = ST_IDLE;
          end
        end
      end
      default: begin
        tx_line_d  = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- RX synchronizer ----------------
  logic rx_meta, rx_sync, rx_last;
  logic rx_fall;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  assign rx_fall = rx_last && !rx_sync;

  // ---------------- RX deserializer ----------------
  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_cnt_last;
  logic          rx_push, rx_frame_set;
`ifdef PARITY_EN
  logic          rx_par_bad_q, rx_par_bad_d;
  logic          rx_par_set;
`endif

  assign rx_cnt_last = (rx_cnt_q == CNT_LAST);

  // RX state register; reset drops any partially assembled byte
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
`ifdef PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
`ifdef PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

  // RX next state: half-bit wait to centre on the start bit, then whole-bit steps
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
`ifdef PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    rx_par_set   = 1'b0;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
`ifdef PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_last) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = (rx_sync != ^rx_shift_q);
          rx_state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_last) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (!rx_sync) begin
            rx_frame_set = 1'b1;
`ifdef PARITY_EN
          end else if (rx_par_bad_q) begin
            rx_par_set = 1'b1;
`endif
          end else begin
            rx_push = 1'b1;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]         rx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [FIFO_AW:0]   rx_count;
  logic               rx_empty, rx_full, rx_pop, rx_wr, rx_overrun_set;

  assign rx_empty       = (rx_count == '0);
  assign rx_full        = (rx_count == FIFO_FULL);
  assign rx_pop         = rx_rden_in && !rx_empty;
  assign rx_wr          = rx_push && (!rx_full || rx_pop);
  assign rx_overrun_set = rx_push && rx_full && !rx_pop;
  assign rx_valid_out   = !rx_empty;
  assign rx_data_out    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // RX FIFO storage; a full FIFO still accepts a byte when the head leaves on the same edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_wr) begin
        rx_mem[rx_wr_ptr] <= rx_shift_q;
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_wr, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun_out    <= 1'b0;
      frame_err_out  <= 1'b0;
`ifdef PARITY_EN
      parity_err_out <= 1'b0;
`endif
    end else begin
      if (rx_overrun_set) overrun_out    <= 1'b1;
      if (rx_frame_set)   frame_err_out  <= 1'b1;
`ifdef PARITY_EN
      if (rx_par_set)     parity_err_out <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb/tb_serial_uart_bridge.sv - self-checking bench for serial_uart_bridge
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data_in;
  logic       tx_wren_in;
  logic       rx_rden_in;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       tx_ready_out;
  logic       uart_tx;
  logic       uart_rx;
  logic       overrun_out;
  logic       frame_err_out;
`ifdef PARITY_EN
  logic       parity_err_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_model [$];
  logic       overrun_model;

  serial_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data_in   (tx_data_in),
    .tx_wren_in   (tx_wren_in),
    .rx_rden_in   (rx_rden_in),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .tx_ready_out (tx_ready_out),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .overrun_out  (overrun_out),
`ifdef PARITY_EN
    .parity_err_out(parity_err_out),
`endif
    .frame_err_out(frame_err_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // nw writes on consecutive edges; expected line is the concatenation of the accepted frames
  task automatic tx_burst(input logic [7:0] first, input int nw);
    logic [7:0] b [8];
    logic [9:0] frame;
    int         nacc, t, k;
    logic       exp_line;
    nacc = (nw < DEPTH + 1) ? nw : DEPTH + 1;
    b[0] = first;
    for (int i = 1; i < 8; i++) b[i] = 8'($urandom);
    for (int j = -1; j < nacc * FRAME + 8; j++) begin
      if (j >= 0) begin
        t = j - 1;
        k = (t < 0) ? nacc : t / FRAME;
        if (k >= nacc) begin
          exp_line = 1'b1;
        end else begin
          frame    = {1'b1, b[3'(k)], 1'b0};
          exp_line = frame[4'((t % FRAME) / CPB)];
        end
        check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_line});
        if (j < nw) check("tx_ready", {31'd0, tx_ready_out}, (j + 1 <= DEPTH) ? 32'd1 : 32'd0);
      end
      if (j + 1 < nw) begin
        tx_wren_in = 1'b1;
        tx_data_in = b[3'(j + 1)];
      end else begin
        tx_wren_in = 1'b0;
      end
      tick(1);
    end
    tx_wren_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(3);
  endtask

  task automatic model_rx(input logic [7:0] data);
    if (rx_model.size() < DEPTH) rx_model.push_back(data);
    else overrun_model = 1'b1;
  endtask

  task automatic pop_one;
    rx_rden_in = 1'b1;
    tick(1);
    rx_rden_in = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] fr;
    int         lows;

    reset         = 1'b0;
    uart_rx       = 1'b1;
    tx_wren_in    = 1'b0;
    tx_data_in    = 8'h00;
    rx_rden_in    = 1'b0;
    overrun_model = 1'b0;
    tick(3);

    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid_out}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready_out}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data_out}, 32'h00);
    check("rst_overrun", {31'd0, overrun_out}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err_out}, 32'd0);
    reset = 1'b1;
    tick(2);

    // single byte, exact bit timing
    tx_burst(8'hA5, 1);
    // five back-to-back bytes plus one dropped write while full
    tx_burst(8'($urandom), 6);

    // one received byte then pop
    send_frame(8'h3C, 1'b1);
    model_rx(8'h3C);
    check("rx_valid_3c", {31'd0, rx_valid_out}, 32'd1);
    check("rx_data_3c", {24'd0, rx_data_out}, {24'd0, rx_model[0]});
    pop_one();
    void'(rx_model.pop_front());
    check("rx_valid_popped", {31'd0, rx_valid_out}, 32'd0);
    check("rx_data_popped", {24'd0, rx_data_out}, 32'h00);
    pop_one();
    check("rx_valid_pop_empty", {31'd0, rx_valid_out}, 32'd0);

    // five frames without reading: fifth overruns
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_rx(d);
      check("overrun_fill", {31'd0, overrun_out}, {31'd0, overrun_model});
      check("rx_valid_fill", {31'd0, rx_valid_out}, 32'd1);
    end
    while (rx_model.size() > 0) begin
      check("rx_data_order", {24'd0, rx_data_out}, {24'd0, rx_model[0]});
      pop_one();
      void'(rx_model.pop_front());
    end
    check("rx_valid_drained", {31'd0, rx_valid_out}, 32'd0);
    check("overrun_sticky", {31'd0, overrun_out}, 32'd1);

    // one-cycle glitch: nothing received, no framing error
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(12);
    check("glitch_rx_valid", {31'd0, rx_valid_out}, 32'd0);
    check("glitch_frame_err", {31'd0, frame_err_out}, 32'd0);

    // stop bit low: byte discarded, framing error
    send_frame(8'($urandom), 1'b0);
    check("badstop_rx_valid", {31'd0, rx_valid_out}, 32'd0);
    check("badstop_frame_err", {31'd0, frame_err_out}, 32'd1);

    // leave a byte in the RX FIFO, then reset mid TX and RX data phases
    send_frame(8'($urandom), 1'b1);
    check("pre_reset_rx_valid", {31'd0, rx_valid_out}, 32'd1);
    d  = 8'($urandom);
    fr = {1'b1, d, 1'b0};
    for (int c = 0; c < 5 * CPB; c++) begin
      uart_rx    = fr[4'(c / CPB)];
      tx_wren_in = (c < 3);
      tx_data_in = 8'($urandom);
      tick(1);
    end
    tx_wren_in = 1'b0;
    reset      = 1'b0;
    uart_rx    = 1'b1;
    tick(1);
    check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_rx_valid", {31'd0, rx_valid_out}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready_out}, 32'd1);
    check("midrst_rx_data", {24'd0, rx_data_out}, 32'h00);
    check("midrst_overrun", {31'd0, overrun_out}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err_out}, 32'd0);
    reset = 1'b1;
    rx_model.delete();
    overrun_model = 1'b0;
    lows = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (uart_tx !== 1'b1) lows++;
      tick(1);
    end
    check("tx_idle_after_reset", lows, 32'd0);

    d = 8'($urandom);
    send_frame(d, 1'b1);
    model_rx(d);
    check("post_reset_rx_valid", {31'd0, rx_valid_out}, 32'd1);
    check("post_reset_rx_data", {24'd0, rx_data_out}, {24'd0, rx_model[0]});
    check("post_reset_frame_err", {31'd0, frame_err_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Sits directly downstream/upstream of the processor's serial IO ports.
- Converts the byte-wide serial strobe interface driven by data_memory into a UART link: a TX FIFO plus serializer, and an RX deserializer plus FIFO.
- Provides serial_in / serial_valid_in / serial_ready_in to the processor and consumes serial_out / serial_wren_out / serial_rden_out.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; integer ≥ 4, even.
- FIFO_DEPTH, 8: entries per FIFO; power of 2, ≥ 2.
- FIFO_AW, 3: pointer width, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low.
- tx_data_in  input  8  byte from processor serial_out.
- tx_wren_in  input  1  processor serial_wren_out; push tx_data_in.
- rx_rden_in  input  1  processor serial_rden_out; pop RX FIFO head.
- rx_data_out  output  8  RX FIFO head, to processor serial_in.
- rx_valid_out  output  1  RX FIFO non-empty, to serial_valid_in.
- tx_ready_out  output  1  TX FIFO not full, to serial_ready_in.
- uart_tx  output  1  serial line out, idle high.
- uart_rx  input  1  serial line in, asynchronous.
- overrun_out  output  1  sticky: received byte dropped, RX FIFO full.
- frame_err_out  output  1  sticky: stop bit sampled low.

Behaviour:
- Reset (reset==0 at posedge):
  - uart_tx=1, rx_valid_out=0, tx_ready_out=1, rx_data_out=8'h00, overrun_out=0, frame_err_out=0.
  - Both FIFOs emptied; both FSMs to IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame immediately; a partial RX byte is discarded.
- TX FIFO:
  - A push occurs on a posedge with tx_wren_in=1 and the FIFO not full.
  - tx_wren_in while full: byte dropped silently, no state change.
  - tx_ready_out=!full, registered count-based.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE with FIFO non-empty: pop head into shift register and go to START. uart_tx=0 from that edge.
  - Byte pushed at edge k starts the start bit at edge k+1.
  - Each state holds for CLKS_PER_BIT cycles.
  - DATA shifts 8 bits LSB first.
  - STOP drives 1.
  - A back-to-back byte begins START directly after STOP's last cycle, with no extra idle cycle.
  - Push and pop on the same edge are both honoured.
- RX synchronizer: uart_rx passes through a 2-flop synchronizer, reset value 1. All RX sampling uses the synchronized value.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: falling edge (synchronized 1 -> 0) enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is 1 (glitch), return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT cycles, mid-bit; 8 bits, LSB first.
  - STOP: sample mid-bit.
    - Stop bit 1: push byte to RX FIFO.
    - Stop bit 0: discard byte and set frame_err_out.
  - After the STOP sample, return to IDLE immediately. The next falling edge may be detected from the following cycle.
- RX FIFO:
  - rx_data_out = head when non-empty, 8'h00 when empty.
  - Pop on posedge with rx_rden_in=1 and non-empty. rx_rden_in while empty is ignored.
  - Push when full with no simultaneous pop: byte dropped, overrun_out set.
  - Push and pop on the same edge while full: both honoured, no overrun.
- Sticky flags clear only on reset.
- Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits, range 0..FIFO_DEPTH.

Optional Feature:
- PARITY_EN defined:
  - A 9th even-parity bit is inserted between DATA and STOP (state PARITY) on TX and checked on RX.
  - RX parity mismatch discards the byte and sets extra output parity_err_out (1-bit sticky, reset 0).
  - Frame length is 11 bits.
- Undefined: no PARITY state, no parity_err_out port, 10-bit frames.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset release, push 8'hA5 -> uart_tx low next edge. Bits 1,0,1,0,0,1,0,1 each for 4 cycles, then stop 1. Total 40 cycles from start to idle.
- Push 5 bytes back-to-back while first transmits -> tx_ready_out drops after 5th accepted write (4 stored + 1 in shifter). A 6th write while full is dropped. Bytes emerge in order with no idle gaps.
- Drive 8'h3C frame on uart_rx -> rx_valid_out=1 and rx_data_out=8'h3C ~2 cycles after stop mid-sample. rx_rden_in pulse -> rx_valid_out=0, rx_data_out=8'h00.
- Receive 5 frames without reading -> first 4 stored in order, overrun_out=1 after 5th. Overrun stays high until reset.
- 1-cycle low glitch on uart_rx -> no byte, no flags. Frame with stop bit 0 -> no byte, frame_err_out=1.
- Assert reset mid-TX-DATA and mid-RX-DATA -> next edge uart_tx=1, FIFOs empty, all flags 0. A subsequent full frame is received correctly.
